pll_drp_ctrl: RTL and testbench
===============================

Name: pll_drp_ctrl

Overview:
Reconfiguration sequencer for the board PLLE2_ADV clock generator, which produces the ADC, DAC, serial and PDM clocks. It accepts a stream of register updates from the control bus, holds the PLL in reset, and applies each update as a read-modify-write over the DRP port. It then releases reset, waits for lock with a timeout, and reports status. It runs on a free-running system clock, never on a PLL output, and monitors loss of lock while idle.

Parameters:
DRP_TO, 64, max cycles from den to drdy before DRP error
LOCK_TO, 65536, max cycles from reset release to synced lock before lock error
RST_MIN, 8, min cycles pll_rst held high before release (>=1)

Ports:
clk  in  1  system clock (free-running, independent of PLL)
rstn  in  1  reset, asynchronous, active-low
cfg_valid  in  1  update entry valid
cfg_ready  out  1  entry accepted when cfg_valid&&cfg_ready
cfg_addr  in  7  DRP register address
cfg_mask  in  16  1 = keep existing bit, 0 = take cfg_data bit
cfg_data  in  16  new bit values
cfg_last  in  1  final entry of the sequence
drp_daddr  out  7  to PLL DADDR
drp_den  out  1  to PLL DEN, single-cycle pulse
drp_dwe  out  1  to PLL DWE, valid with den
drp_di  out  16  to PLL DI
drp_do  in  16  from PLL DO
drp_drdy  in  1  from PLL DRDY
pll_rst  out  1  to PLL RST
pll_locked  in  1  PLL LOCKED, asynchronous to clk
busy  out  1  sequence in progress
done  out  1  one-cycle pulse, sequence ended (success or error)
err_drp  out  1  sticky, DRP timeout
err_lock  out  1  sticky, lock timeout
lock_lost  out  1  sticky, synced lock fell while IDLE
lock_clr  in  1  clears lock_lost

Behaviour:
- Reset values: pll_rst=1, cfg_ready=0, drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0, busy=0, done=0, err_drp=0, err_lock=0, lock_lost=0, FSM=IDLE.
- Async reset mid-operation aborts immediately and forces all outputs to reset values, including pll_rst=1. On the first clk after release, pll_rst=0 and the PLL relocks with its current DRP contents.
- pll_locked passes through a 2-flop synchroniser (lk_s). All lock decisions use lk_s.
- IDLE: cfg_ready=1, pll_rst=0. Accepting an entry latches addr/mask/data/last, clears err_drp/err_lock, sets busy=1 and pll_rst=1, then goes to RD.
- RD: one cycle with den=1, dwe=0, daddr=addr. Goes to RD_WAIT.
- RD_WAIT: on drdy, capture wv = (drp_do & mask) | (data & ~mask), then go to WR.
- WR: one cycle with den=1, dwe=1, daddr=addr, di=wv. Goes to WR_WAIT.
- WR_WAIT: on drdy, go to RELEASE if last=1, else NEXT.
- DRP timeout: the wait counter resets on den. If drdy has not arrived after DRP_TO cycles in RD_WAIT or WR_WAIT, set err_drp=1 and go to RELEASE.
- drdy outside the wait states is ignored.
- NEXT: cfg_ready=1, pll_rst stays 1. Waits indefinitely for the next entry; on acceptance, go to RD. cfg_ready=0 in all other states except IDLE.
- RELEASE: holds pll_rst=1 until at least RST_MIN cycles have elapsed since pll_rst rose. Then drives pll_rst=0 and goes to LOCK_WAIT.
- LOCK_WAIT: counter starts at 0 on entry. If lk_s=1, go to DONE. If the counter reaches LOCK_TO first, set err_lock=1 and go to DONE. A lock that arrives in the same cycle as timeout counts as success.
- DONE: done=1 for one cycle, busy=0, return to IDLE. The error flags keep their values until the next accepted entry.
- lock_lost is set on a 1->0 transition of lk_s while the FSM is IDLE and not within the first 2 cycles after reset. If lock_clr and a fall occur in the same cycle, set wins.
- Counter widths are $clog2(param)+1 and saturate, with no wrap-around.

Test Plan:
- Single entry addr=0x08, mask=0xF000, data=0x0104, drp_do=0xA555, last=1 -> read then write with di=0xA104; pll_rst=1 from accept until >=8 cycles; locked raised 100 cycles after release -> done pulse 2-3 cycles later (synchroniser), no errors.
- Three entries with cfg_valid low for 50 cycles between the 2nd and 3rd -> exactly 3 read/write pairs; pll_rst stays 1 throughout the gap; only one done pulse.
- drp_drdy never returned for the read -> err_drp=1 after 64 cycles, no write issued, pll_rst released, done pulse; next accepted entry clears err_drp.
- pll_locked held low -> err_lock=1 at 65536 cycles after release, done pulse. Repeat with locked rising in the exact timeout cycle -> err_lock=0.
- rstn asserted during WR_WAIT -> all outputs at reset values asynchronously, pll_rst=1; after release the FSM is in IDLE with cfg_ready=1 and pll_rst=0.
- Idle with lock, then drop pll_locked -> lock_lost=1 within 3 cycles. lock_clr for one cycle -> 0. lock_clr coinciding with a new fall -> stays 1.

Source files
------------

// File: rtl/pll_drp_ctrl.sv
// PLL DRP reconfiguration sequencer: read-modify-write each update with the PLL in reset, then relock.
// Latency: two DRP accesses per entry plus DRP response time; lock wait bounded by LOCK_TO cycles.
// Backpressure: cfg_ready only in IDLE and NEXT; DRP and lock waits are bounded by timeouts.
module pll_drp_ctrl #(
    parameter int DRP_TO  = 64,
    parameter int LOCK_TO = 65536,
    parameter int RST_MIN = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [6:0]  cfg_addr,
    input  logic [15:0] cfg_mask,
    input  logic [15:0] cfg_data,
    input  logic        cfg_last,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        pll_rst,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        err_drp,
    output logic        err_lock,
    output logic        lock_lost,
    input  logic        lock_clr
);
    localparam int DW = $clog2(DRP_TO) + 1;
    localparam int LW = $clog2(LOCK_TO) + 1;
    localparam int RW = $clog2(RST_MIN) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_NEXT, S_RELEASE, S_LOCK_WAIT, S_DONE
    } state_t;

    state_t        state;
    logic [15:0]   mask_q;
    logic [15:0]   data_q;
    logic          last_q;
    logic [DW-1:0] wait_cnt;
    logic [LW-1:0] lock_cnt;
    logic [RW-1:0] rst_cnt;
    logic          lk_m, lk_s, lk_d;
    logic [1:0]    arm_cnt;
    logic          take, lk_fall, drp_tmo;

    assign take    = cfg_valid && cfg_ready && (state == S_IDLE || state == S_NEXT);
    assign lk_fall = lk_d && !lk_s && (arm_cnt == 2'd2);
    assign drp_tmo = (wait_cnt == DW'(DRP_TO - 1));

    // pll_locked comes from the PLL's own domain; only lk_s is used below.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lk_m    <= 1'b0;
            lk_s    <= 1'b0;
            lk_d    <= 1'b0;
            arm_cnt <= 2'd0;
        end else begin
            lk_m <= pll_locked;
            lk_s <= lk_m;
            lk_d <= lk_s;
            if (arm_cnt != 2'd2) arm_cnt <= arm_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cfg_ready <= 1'b0;
            drp_daddr <= '0;
            drp_den   <= 1'b0;
            drp_dwe   <= 1'b0;
            drp_di    <= '0;
            pll_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_drp   <= 1'b0;
            err_lock  <= 1'b0;
            lock_lost <= 1'b0;
            mask_q    <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            wait_cnt  <= '0;
            lock_cnt  <= '0;
            rst_cnt   <= '0;
        end else begin
            drp_den <= 1'b0;
            drp_dwe <= 1'b0;
            done    <= 1'b0;
            if (pll_rst && rst_cnt != '1) rst_cnt <= rst_cnt + 1'b1;

            // A fall seen in the same cycle as lock_clr must not be lost.
            if (lk_fall && state == S_IDLE) lock_lost <= 1'b1;
            else if (lock_clr)              lock_lost <= 1'b0;

            case (state)
                S_IDLE: begin
                    cfg_ready <= 1'b1;
                    pll_rst   <= 1'b0;
                end
                S_RD: begin
                    wait_cnt <= '0;
                    state    <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (drp_drdy) begin
                        drp_di  <= (drp_do & mask_q) | (data_q & ~mask_q);
                        drp_den <= 1'b1;
                        drp_dwe <= 1'b1;
                        state   <= S_WR;
                    end else if (drp_tmo) begin
                        err_drp <= 1'b1;
                        state   <= S_RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WR: begin
                    wait_cnt <= '0;
                    state    <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (drp_drdy) begin
                        if (last_q) begin
                            state <= S_RELEASE;
                        end else begin
                            cfg_ready <= 1'b1;
                            state     <= S_NEXT;
                        end
                    end else if (drp_tmo) begin
                        err_drp <= 1'b1;
                        state   <= S_RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                end
                S_RELEASE: begin
                    // rst_cnt lags the high time by one, hence RST_MIN-1.
                    if (rst_cnt >= RW'(RST_MIN - 1)) begin
                        pll_rst  <= 1'b0;
                        lock_cnt <= '0;
                        state    <= S_LOCK_WAIT;
                    end
                end
                S_LOCK_WAIT: begin
                    if (lk_s) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (lock_cnt == LW'(LOCK_TO - 1)) begin
                        err_lock <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    cfg_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (take) begin
                drp_daddr <= cfg_addr;
                mask_q    <= cfg_mask;
                data_q    <= cfg_data;
                last_q    <= cfg_last;
                drp_den   <= 1'b1;
                cfg_ready <= 1'b0;
                busy      <= 1'b1;
                pll_rst   <= 1'b1;
                err_drp   <= 1'b0;
                err_lock  <= 1'b0;
                if (state == S_IDLE) rst_cnt <= '0;
                state     <= S_RD;
            end
        end
    end
endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Bench for pll_drp_ctrl: directed sequences plus random update streams, checked against a
// register-file model of the PLL DRP space and the timing rules for reset, lock and timeouts.
module tb_pll_drp_ctrl;
    localparam int DRP_TO  = 64;
    localparam int LOCK_TO = 300;
    localparam int RST_MIN = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_valid, cfg_ready, cfg_last;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_mask, cfg_data;
    logic [6:0]  drp_daddr;
    logic        drp_den, drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do = '0;
    logic        drp_drdy = 1'b0;
    logic        pll_rst, pll_locked;
    logic        busy, done, err_drp, err_lock, lock_lost, lock_clr;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [128];
    logic [15:0] exp_mem [128];
    bit          mem_init_done = 0;
    int          n_rd = 0, n_wr = 0, done_cnt = 0, pend = 0, mcnt = 0;
    logic [15:0] rd_val = '0;
    bit          drp_mute = 0, auto_lock = 0, man_lk = 0, mlk = 0;

    assign pll_locked = auto_lock ? mlk : man_lk;

    always #5 clk = ~clk;

    pll_drp_ctrl #(.DRP_TO(DRP_TO), .LOCK_TO(LOCK_TO), .RST_MIN(RST_MIN)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
        .cfg_mask(cfg_mask), .cfg_data(cfg_data), .cfg_last(cfg_last),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy),
        .pll_rst(pll_rst), .pll_locked(pll_locked),
        .busy(busy), .done(done), .err_drp(err_drp), .err_lock(err_lock),
        .lock_lost(lock_lost), .lock_clr(lock_clr)
    );

    // PLL model: DRP register file with random response latency, plus auto-relock after reset.
    always @(negedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
            mem[8] = 16'hA555;
            mem_init_done = 1;
        end
        drp_drdy = 1'b0;
        drp_do   = 16'($urandom);
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                drp_drdy = 1'b1;
                drp_do   = rd_val;
            end
        end
        if (drp_den === 1'b1) begin
            if (drp_dwe === 1'b1) begin
                mem[drp_daddr] = drp_di;
                n_wr++;
            end else begin
                rd_val = mem[drp_daddr];
                n_rd++;
            end
            if (!drp_mute) pend = $urandom_range(1, 4);
        end
        if (pll_rst !== 1'b0) begin
            mlk  = 0;
            mcnt = 0;
        end else if (mcnt < 20) begin
            mcnt++;
        end else begin
            mlk = 1;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                        input logic l, input bit upd);
        int t;
        cfg_addr = a; cfg_mask = m; cfg_data = d; cfg_last = l; cfg_valid = 1'b1;
        t = 0;
        while (cfg_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("accept", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        if (upd) exp_mem[a] = (exp_mem[a] & m) | (d & ~m);
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        chk(tag, done, 1);
    endtask

    task automatic wait_release(input string tag);
        int t;
        t = 0;
        while (pll_rst !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, pll_rst, 0);
    endtask

    task automatic chk_regs(input string tag);
        int nbad;
        nbad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== exp_mem[i]) nbad++;
        chk(tag, nbad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, rd0, wr0, d0, cnt, bad, n;
        cfg_valid = 0; cfg_addr = 0; cfg_mask = 0; cfg_data = 0; cfg_last = 0; lock_clr = 0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #4;
        chk("reset_ctrl", {pll_rst, cfg_ready, drp_den, drp_dwe, busy, done, err_drp, err_lock, lock_lost}, 9'h100);
        chk("reset_drp_bus", {drp_daddr, drp_di}, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {cfg_ready, pll_rst, busy}, 3'b100);
        for (int i = 0; i < 128; i++) exp_mem[i] = mem[i];

        // Directed single entry, manual lock 100 cycles after release.
        rd0 = n_rd; wr0 = n_wr;
        send(7'h08, 16'hF000, 16'h0104, 1'b1, 1'b1);
        chk("t1_rst_on_accept", {pll_rst, busy, cfg_ready}, 3'b110);
        cnt = 1;
        for (int t = 0; t < 500 && pll_rst === 1'b1; t++) begin
            @(negedge clk);
            if (pll_rst === 1'b1) cnt++;
        end
        chk("t1_rst_min", (cnt >= RST_MIN), 1);
        chk("t1_rd_wr_count", {8'(n_rd - rd0), 8'(n_wr - wr0)}, 16'h0101);
        chk("t1_write_value", mem[8], 16'hA104);
        repeat (100) @(negedge clk);
        chk("t1_waiting", {busy, done, err_lock}, 3'b100);
        man_lk = 1;
        wait_done("t1_done", lat);
        chk("t1_lock_latency", (lat >= 2 && lat <= 3), 1);
        chk("t1_no_err", {err_drp, err_lock}, 0);
        @(negedge clk);
        chk("t1_done_pulse", {done, busy, cfg_ready}, 3'b001);

        // Three entries with a 50-cycle gap before the last.
        rd0 = n_rd; wr0 = n_wr; d0 = done_cnt;
        send(7'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b1);
        auto_lock = 1;
        send(7'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (pll_rst !== 1'b1) bad++;
        end
        chk("t2_rst_held_in_gap", bad, 0);
        chk("t2_ready_in_gap", {cfg_ready, busy}, 2'b11);
        send(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        wait_done("t2_done", lat);
        repeat (5) @(negedge clk);
        chk("t2_one_done", done_cnt - d0, 1);
        chk("t2_rd_wr_count", {8'(n_rd - rd0), 8'(n_wr - wr0)}, 16'h0303);
        chk_regs("t2_regs");

        // DRP read never answered.
        drp_mute = 1;
        wr0 = n_wr;
        send(7'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        repeat (62) @(negedge clk);
        chk("t3_err_drp_early", err_drp, 0);
        repeat (4) @(negedge clk);
        chk("t3_err_drp_set", err_drp, 1);
        wait_done("t3_done", lat);
        @(negedge clk);
        chk("t3_after", {8'(n_wr - wr0), 4'(err_drp), 4'(pll_rst)}, 16'h0010);
        drp_mute = 0;
        repeat (4) @(negedge clk);
        send(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        chk("t3_err_cleared", err_drp, 0);
        wait_done("t3_done2", lat);
        chk_regs("t3_regs");

        // Random update streams.
        for (int s = 0; s < 4; s++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                send(7'($urandom), 16'($urandom), 16'($urandom), (k == n - 1), 1'b1);
            end
            wait_done("rand_done", lat);
            chk("rand_no_err", {err_drp, err_lock}, 0);
            chk_regs("rand_regs");
        end

        // Lock never arrives.
        repeat (3) @(negedge clk);
        send(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        auto_lock = 0;
        man_lk = 0;
        wait_release("t4_release");
        repeat (LOCK_TO - 1) @(negedge clk);
        chk("t4_before_timeout", {done, err_lock}, 2'b00);
        @(negedge clk);
        chk("t4_timeout", {done, err_lock}, 2'b11);
        @(negedge clk);
        chk("t4_err_sticky", {err_lock, busy, done}, 3'b100);

        // Lock arrives exactly in the timeout cycle.
        send(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        chk("t4b_err_cleared", err_lock, 0);
        wait_release("t4b_release");
        repeat (LOCK_TO - 3) @(negedge clk);
        man_lk = 1;
        repeat (2) @(negedge clk);
        chk("t4b_before", done, 0);
        @(negedge clk);
        chk("t4b_done_ok", {done, err_lock}, 2'b10);
        chk_regs("t4_regs");

        // Async reset while waiting for the write response.
        repeat (3) @(negedge clk);
        send(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        for (int t = 0; t < 200 && !(drp_den === 1'b1 && drp_dwe === 1'b1); t++) @(negedge clk);
        chk("t5_reach_write", {drp_den, drp_dwe}, 2'b11);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("t5_reset_ctrl", {pll_rst, cfg_ready, drp_den, drp_dwe, busy, done, err_drp, err_lock, lock_lost}, 9'h100);
        chk("t5_reset_drp_bus", {drp_daddr, drp_di}, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("t5_idle_after", {cfg_ready, pll_rst, busy}, 3'b100);
        chk_regs("t5_regs");

        // Loss of lock while idle.
        repeat (6) @(negedge clk);
        chk("t6_no_loss", lock_lost, 0);
        man_lk = 0;
        repeat (3) @(negedge clk);
        chk("t6_loss_set", lock_lost, 1);
        lock_clr = 1;
        @(negedge clk);
        lock_clr = 0;
        chk("t6_cleared", lock_lost, 0);
        man_lk = 1;
        repeat (4) @(negedge clk);
        chk("t6_rise_ignored", lock_lost, 0);
        man_lk = 0;
        repeat (2) @(negedge clk);
        lock_clr = 1;
        @(negedge clk);
        lock_clr = 0;
        chk("t6_set_wins", lock_lost, 1);
        @(negedge clk);
        chk("t6_sticky", lock_lost, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
